// File: rtl/dmem_arbiter_pkg.sv
// rtl/dmem_arbiter_pkg.sv - shared types and constants for the data-memory arbiter
package dmem_arbiter_pkg;

  typedef enum logic [1:0] {
    ARB_NONE = 2'd0,
    ARB_M0   = 2'd1,
    ARB_M1   = 2'd2
  } arb_owner_t;

  localparam int DMEM_ARB_MAX_BURST = 4;
  localparam int DMEM_ADDR_W        = 32;
  localparam int DMEM_DATA_W        = 32;

  // Command captured by the issue stage
  typedef struct packed {
    logic                   we;
    logic [DMEM_ADDR_W-1:0] addr;
    logic [DMEM_DATA_W-1:0] wdata;
  } dmem_cmd_t;

  // The master that is not o (NONE maps to M0)
  function automatic arb_owner_t arb_other(input arb_owner_t o);
    return (o == ARB_M0) ? ARB_M1 : ARB_M0;
  endfunction

endpackage

// File: rtl/dmem_arb_ctrl.sv
// rtl/dmem_arb_ctrl.sv - owner FSM with round-robin tie break and burst limit
module dmem_arb_ctrl
  import dmem_arbiter_pkg::*;
#(
  parameter int MAX_BURST = DMEM_ARB_MAX_BURST
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       m0_req_i,
  input  logic       m1_req_i,
  output arb_owner_t owner_o,
  output arb_owner_t owner_nxt_o
);

  // One spare code above MAX_BURST so the increment never wraps
  localparam int BW = $clog2(MAX_BURST + 2);

  arb_owner_t    owner_q, owner_d;
  arb_owner_t    rr_last_q, rr_last_d;
  logic [BW-1:0] burst_q, burst_d, burst_inc;
  logic          own_req, oth_req;

  // Next owner: accepts count toward the burst; hand over on limit or on release
  always_comb begin
    owner_d   = owner_q;
    rr_last_d = rr_last_q;
    burst_d   = burst_q;
    burst_inc = burst_q + 1'b1;
    own_req   = (owner_q == ARB_M0) ? m0_req_i : m1_req_i;
    oth_req   = (owner_q == ARB_M0) ? m1_req_i : m0_req_i;
    case (owner_q)
      ARB_M0, ARB_M1: begin
        if (own_req) begin
          if (oth_req && (burst_inc >= BW'(MAX_BURST))) begin
            owner_d   = arb_other(owner_q);
            rr_last_d = owner_q;
            burst_d   = '0;
          end else if (burst_q != BW'(MAX_BURST)) begin
            burst_d = burst_inc;
          end
        end else begin
          burst_d = '0;
          owner_d = oth_req ? arb_other(owner_q) : ARB_NONE;
        end
      end
      default: begin
        burst_d = '0;
        if (m0_req_i && m1_req_i) owner_d = arb_other(rr_last_q);
        else if (m0_req_i)        owner_d = ARB_M0;
        else if (m1_req_i)        owner_d = ARB_M1;
        else                      owner_d = ARB_NONE;
      end
    endcase
  end

  // State register; rr_last starts at M1 so m0 wins the first tie
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      owner_q   <= ARB_NONE;
      rr_last_q <= ARB_M1;
      burst_q   <= '0;
    end else begin
      owner_q   <= owner_d;
      rr_last_q <= rr_last_d;
      burst_q   <= burst_d;
    end
  end

  assign owner_o     = owner_q;
  assign owner_nxt_o = owner_d;

endmodule

// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - two-master data-memory arbiter; optional counters under DMEM_ARB_STATS_EN
module dmem_arbiter
  import dmem_arbiter_pkg::*;
#(
  parameter int ADDR_WIDTH = DMEM_ADDR_W,
  parameter int DATA_WIDTH = DMEM_DATA_W,
  parameter int MAX_BURST  = DMEM_ARB_MAX_BURST
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  m0_req,
  input  logic                  m0_we,
  input  logic [ADDR_WIDTH-1:0] m0_addr,
  input  logic [DATA_WIDTH-1:0] m0_wdata,
  output logic                  m0_gnt,
  output logic [DATA_WIDTH-1:0] m0_rdata,
  output logic                  m0_rvalid,
  input  logic                  m1_req,
  input  logic                  m1_we,
  input  logic [ADDR_WIDTH-1:0] m1_addr,
  input  logic [DATA_WIDTH-1:0] m1_wdata,
  output logic                  m1_gnt,
  output logic [DATA_WIDTH-1:0] m1_rdata,
  output logic                  m1_rvalid,
  output logic [ADDR_WIDTH-1:0] mem_address,
  output logic                  mem_write_en,
  output logic [DATA_WIDTH-1:0] mem_data_in,
  input  logic [DATA_WIDTH-1:0] mem_data_out,
  output logic [1:0]            owner
`ifdef DMEM_ARB_STATS_EN
  ,
  output logic [31:0]           m0_acc_cnt,
  output logic [31:0]           m1_acc_cnt,
  output logic [31:0]           m1_wait_cnt
`endif
);

  arb_owner_t            owner_cur, owner_nxt;
  logic                  acc0, acc1, acc;
  dmem_cmd_t             cmd_d, cmd_q;
  logic                  stage_valid_q, stage_src_q, mem_we_q;
  logic                  gnt0_q, gnt1_q;
  logic                  rd0_hit, rd1_hit;
  logic                  rvalid0_q, rvalid1_q;
  logic [DATA_WIDTH-1:0] rdata0_q, rdata1_q;

  dmem_arb_ctrl #(.MAX_BURST(MAX_BURST)) u_ctrl (
    .clk         (clk),
    .rst_n       (rst_n),
    .m0_req_i    (m0_req),
    .m1_req_i    (m1_req),
    .owner_o     (owner_cur),
    .owner_nxt_o (owner_nxt)
  );

  assign acc0 = m0_req & (owner_cur == ARB_M0);
  assign acc1 = m1_req & (owner_cur == ARB_M1);
  assign acc  = acc0 | acc1;

  // Command mux: at most one master owns the port
  always_comb begin
    cmd_d = '{we: m0_we, addr: m0_addr, wdata: m0_wdata};
    if (acc1) cmd_d = '{we: m1_we, addr: m1_addr, wdata: m1_wdata};
  end

  // Grants are flopped from the next owner so they match the owner register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gnt0_q <= 1'b0;
      gnt1_q <= 1'b0;
    end else begin
      gnt0_q <= (owner_nxt == ARB_M0);
      gnt1_q <= (owner_nxt == ARB_M1);
    end
  end

  // Issue stage: address/data hold when idle, write strobe only for a fresh write
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stage_valid_q <= 1'b0;
      stage_src_q   <= 1'b0;
      mem_we_q      <= 1'b0;
      cmd_q         <= '0;
    end else begin
      stage_valid_q <= acc;
      mem_we_q      <= acc & cmd_d.we;
      if (acc) begin
        stage_src_q <= acc1;
        cmd_q       <= cmd_d;
      end
    end
  end

  assign rd0_hit = stage_valid_q & ~cmd_q.we & ~stage_src_q;
  assign rd1_hit = stage_valid_q & ~cmd_q.we &  stage_src_q;

  // Read return: sample the memory one edge after issue, hold until the next read
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rvalid0_q <= 1'b0;
      rvalid1_q <= 1'b0;
      rdata0_q  <= '0;
      rdata1_q  <= '0;
    end else begin
      rvalid0_q <= rd0_hit;
      rvalid1_q <= rd1_hit;
      if (rd0_hit) rdata0_q <= mem_data_out;
      if (rd1_hit) rdata1_q <= mem_data_out;
    end
  end

  assign m0_gnt       = gnt0_q;
  assign m1_gnt       = gnt1_q;
  assign m0_rvalid    = rvalid0_q;
  assign m1_rvalid    = rvalid1_q;
  assign m0_rdata     = rdata0_q;
  assign m1_rdata     = rdata1_q;
  assign mem_address  = cmd_q.addr;
  assign mem_data_in  = cmd_q.wdata;
  assign mem_write_en = mem_we_q;
  assign owner        = owner_cur;

`ifdef DMEM_ARB_STATS_EN
  logic [31:0] m0_acc_q, m1_acc_q, m1_wait_q;

  // Saturating accept and m1 wait counters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m0_acc_q  <= '0;
      m1_acc_q  <= '0;
      m1_wait_q <= '0;
    end else begin
      if (acc0 && (m0_acc_q != '1)) m0_acc_q <= m0_acc_q + 1'b1;
      if (acc1 && (m1_acc_q != '1)) m1_acc_q <= m1_acc_q + 1'b1;
      if (m1_req && !gnt1_q && (m1_wait_q != '1)) m1_wait_q <= m1_wait_q + 1'b1;
    end
  end

  assign m0_acc_cnt  = m0_acc_q;
  assign m1_acc_cnt  = m1_acc_q;
  assign m1_wait_cnt = m1_wait_q;
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb/tb_dmem_arbiter.sv - randomized self-checking bench for dmem_arbiter
module tb_dmem_arbiter;
  localparam int MAXB = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        m0_req = 0, m0_we = 0, m1_req = 0, m1_we = 0;
  logic [31:0] m0_addr = 0, m0_wdata = 0, m1_addr = 0, m1_wdata = 0;
  logic        m0_gnt, m1_gnt, m0_rvalid, m1_rvalid, mem_write_en;
  logic [31:0] m0_rdata, m1_rdata, mem_address, mem_data_in, mem_data_out;
  logic [1:0]  owner;
`ifdef DMEM_ARB_STATS_EN
  logic [31:0] m0_acc_cnt, m1_acc_cnt, m1_wait_cnt;
`endif

  dmem_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_gnt(m0_gnt), .m0_rdata(m0_rdata), .m0_rvalid(m0_rvalid),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_gnt(m1_gnt), .m1_rdata(m1_rdata), .m1_rvalid(m1_rvalid),
    .mem_address(mem_address), .mem_write_en(mem_write_en),
    .mem_data_in(mem_data_in), .mem_data_out(mem_data_out),
    .owner(owner)
`ifdef DMEM_ARB_STATS_EN
    , .m0_acc_cnt(m0_acc_cnt), .m1_acc_cnt(m1_acc_cnt), .m1_wait_cnt(m1_wait_cnt)
`endif
  );

  always #5 clk = ~clk;

  // Environment memory: synchronous write, combinational read
  logic [31:0] env_mem [0:255];
  logic [31:0] ref_mem [0:255];
  assign mem_data_out = env_mem[mem_address[9:2]];
  always @(posedge clk) if (mem_write_en) env_mem[mem_address[9:2]] <= mem_data_in;

  int total = 0;
  int bad   = 0;

  // Reference model state
  int          m_owner, m_burst, m_rr, m_ssrc;
  bit          m_sv, m_swe, e_rv0, e_rv1, e_we, last_a0, last_a1;
  logic [31:0] m_sdata, e_rd0, e_rd1, e_addr, e_wdata;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    m_owner = 0; m_burst = 0; m_rr = 2; m_ssrc = 0;
    m_sv = 0; m_swe = 0; e_rv0 = 0; e_rv1 = 0; e_we = 0;
    last_a0 = 0; last_a1 = 0;
    m_sdata = 0; e_rd0 = 0; e_rd1 = 0; e_addr = 0; e_wdata = 0;
  endtask

  // Advance the model across one edge using the inputs currently driven
  task automatic model_edge();
    bit          a0, a1, w, rk, ro;
    logic [31:0] ad, wd;
    int          nxt;
    a0 = m0_req && (m_owner == 1);
    a1 = m1_req && (m_owner == 2);
    e_rv0 = m_sv && !m_swe && (m_ssrc == 0);
    e_rv1 = m_sv && !m_swe && (m_ssrc == 1);
    if (e_rv0) e_rd0 = m_sdata;
    if (e_rv1) e_rd1 = m_sdata;
    m_sv = a0 || a1;
    e_we = 0;
    if (m_sv) begin
      ad = a1 ? m1_addr : m0_addr;
      wd = a1 ? m1_wdata : m0_wdata;
      w  = a1 ? m1_we : m0_we;
      m_ssrc = a1 ? 1 : 0;
      m_swe = w; e_we = w; e_addr = ad; e_wdata = wd;
      m_sdata = ref_mem[ad[9:2]];
      if (w) ref_mem[ad[9:2]] = wd;
    end
    last_a0 = a0; last_a1 = a1;
    nxt = m_owner;
    if (m_owner == 0) begin
      m_burst = 0;
      if (m0_req && m1_req) nxt = (m_rr == 1) ? 2 : 1;
      else if (m0_req) nxt = 1;
      else if (m1_req) nxt = 2;
    end else begin
      rk = (m_owner == 1) ? m0_req : m1_req;
      ro = (m_owner == 1) ? m1_req : m0_req;
      if (rk) begin
        if (ro && (m_burst + 1 >= MAXB)) begin
          m_rr = m_owner; nxt = 3 - m_owner; m_burst = 0;
        end else if (m_burst < MAXB) m_burst++;
      end else begin
        m_burst = 0;
        nxt = ro ? 3 - m_owner : 0;
      end
    end
    m_owner = nxt;
  endtask

  task automatic do_reset();
    m0_req = 0; m1_req = 0; m0_we = 0; m1_we = 0;
    rst_n = 0;
    tick();
    rst_n = 1;
    model_reset();
  endtask

  task automatic test_reset();
    tick();
    total++; if (owner !== 2'd0) begin bad++; $display("FAIL reset_owner got=%0d exp=0", owner); end
    total++; if ({m0_gnt, m1_gnt, m0_rvalid, m1_rvalid, mem_write_en} !== 5'b0) begin bad++; $display("FAIL reset_flags got=%b exp=00000", {m0_gnt, m1_gnt, m0_rvalid, m1_rvalid, mem_write_en}); end
    total++; if ({m0_rdata, m1_rdata, mem_address, mem_data_in} !== 128'b0) begin bad++; $display("FAIL reset_data got=%h exp=0", {m0_rdata, m1_rdata, mem_address, mem_data_in}); end
    rst_n = 1;
    model_reset();
    tick();
    total++; if (owner !== 2'd0) begin bad++; $display("FAIL idle_owner got=%0d exp=0", owner); end
  endtask

  task automatic test_write_read();
    m0_req = 1; m0_we = 1; m0_addr = 32'h10; m0_wdata = 32'hDEADBEEF;
    tick();
    total++; if (m0_gnt !== 1'b1) begin bad++; $display("FAIL wr_gnt got=%b exp=1", m0_gnt); end
    tick();
    ref_mem[4] = 32'hDEADBEEF;
    total++; if (mem_write_en !== 1'b1 || mem_address !== 32'h10 || mem_data_in !== 32'hDEADBEEF) begin
      bad++; $display("FAIL wr_issue got=%b/%h/%h exp=1/10/deadbeef", mem_write_en, mem_address, mem_data_in); end
    m0_we = 0;
    tick();
    total++; if (mem_write_en !== 1'b0 || mem_address !== 32'h10) begin bad++; $display("FAIL rd_issue got=%b/%h exp=0/10", mem_write_en, mem_address); end
    total++; if (m0_rvalid !== 1'b0) begin bad++; $display("FAIL wr_no_rvalid got=%b exp=0", m0_rvalid); end
    m0_req = 0;
    tick();
    total++; if (m0_rvalid !== 1'b1 || m0_rdata !== 32'hDEADBEEF) begin bad++; $display("FAIL raw_read got=%b/%h exp=1/deadbeef", m0_rvalid, m0_rdata); end
    total++; if (owner !== 2'd0) begin bad++; $display("FAIL release_owner got=%0d exp=0", owner); end
    tick();
    total++; if (m0_rvalid !== 1'b0 || m0_rdata !== 32'hDEADBEEF) begin bad++; $display("FAIL rdata_hold got=%b/%h exp=0/deadbeef", m0_rvalid, m0_rdata); end
  endtask

  task automatic test_tie();
    do_reset();
    m0_req = 1; m1_req = 1; m0_addr = 32'h20; m1_addr = 32'h24;
    tick();
    total++; if (owner !== 2'd1 || m0_gnt !== 1'b1 || m1_gnt !== 1'b0) begin bad++; $display("FAIL tie_first got=%0d/%b/%b exp=1/1/0", owner, m0_gnt, m1_gnt); end
    tick();
    m0_req = 0;
    tick();
    total++; if (owner !== 2'd2 || m1_gnt !== 1'b1 || m0_gnt !== 1'b0) begin bad++; $display("FAIL tie_handover got=%0d/%b/%b exp=2/0/1", owner, m0_gnt, m1_gnt); end
    tick();
    m1_req = 0;
    tick(); tick();
  endtask

  task automatic test_back_to_back();
    int wait_exp, exp_own;
    do_reset();
    m0_req = 1; m1_req = 1; m0_we = 0; m1_we = 0;
    wait_exp = 1;
    tick();
    for (int i = 0; i < 32; i++) begin
      exp_own = ((i / MAXB) % 2 == 0) ? 1 : 2;
      total++; if (owner !== 2'(exp_own)) begin bad++; $display("FAIL burst_owner i=%0d got=%0d exp=%0d", i, owner, exp_own); end
      total++; if (m0_gnt !== (exp_own == 1)) begin bad++; $display("FAIL burst_gnt i=%0d got=%b exp=%b", i, m0_gnt, exp_own == 1); end
      if (exp_own == 1) wait_exp++;
      m0_addr = 32'($urandom_range(0, 255)) << 2;
      m1_addr = 32'($urandom_range(0, 255)) << 2;
      tick();
    end
    m0_req = 0; m1_req = 0;
`ifdef DMEM_ARB_STATS_EN
    total++; if (m0_acc_cnt !== 32'd16 || m1_acc_cnt !== 32'd16) begin bad++; $display("FAIL acc_cnt got=%0d/%0d exp=16/16", m0_acc_cnt, m1_acc_cnt); end
    total++; if (m1_wait_cnt !== 32'(wait_exp)) begin bad++; $display("FAIL wait_cnt got=%0d exp=%0d", m1_wait_cnt, wait_exp); end
`endif
    tick(); tick(); tick();
  endtask

  task automatic test_m1_alone();
    logic [31:0] expq[$];
    logic [31:0] ev;
    int          idx, nrv, n0;
    do_reset();
    nrv = 0; n0 = 0;
    idx = $urandom_range(0, 255);
    m1_req = 1; m1_we = 0; m1_addr = 32'(idx) << 2;
    tick();
    for (int j = 0; j < 13; j++) begin
      if (j < 10) begin
        total++; if (owner !== 2'd2 || m1_gnt !== 1'b1) begin bad++; $display("FAIL m1_own j=%0d got=%0d/%b exp=2/1", j, owner, m1_gnt); end
        expq.push_back(ref_mem[idx]);
      end
      tick();
      if (m0_rvalid) n0++;
      if (m1_rvalid) begin
        total++;
        if (expq.size() == 0) begin bad++; $display("FAIL m1_extra_rvalid got=%h exp=none", m1_rdata); end
        else begin
          ev = expq.pop_front();
          if (m1_rdata !== ev) begin bad++; $display("FAIL m1_rdata n=%0d got=%h exp=%h", nrv, m1_rdata, ev); end
        end
        nrv++;
      end
      idx = $urandom_range(0, 255);
      m1_addr = 32'(idx) << 2;
      if (j == 9) m1_req = 0;
    end
    total++; if (nrv != 10 || n0 != 0) begin bad++; $display("FAIL m1_pulses got=%0d/%0d exp=10/0", nrv, n0); end
  endtask

  task automatic test_reset_mid_write();
    do_reset();
    m1_req = 1; m1_we = 1; m1_addr = 32'h40; m1_wdata = 32'h12345678;
    tick();
    total++; if (m1_gnt !== 1'b1) begin bad++; $display("FAIL rst_pre_gnt got=%b exp=1", m1_gnt); end
    rst_n = 0;
    #1;
    total++; if (owner !== 2'd0 || m1_gnt !== 1'b0) begin bad++; $display("FAIL rst_async got=%0d/%b exp=0/0", owner, m1_gnt); end
    tick();
    total++; if (mem_write_en !== 1'b0) begin bad++; $display("FAIL rst_we got=%b exp=0", mem_write_en); end
    rst_n = 1; m1_req = 0; m1_we = 0;
    model_reset();
    tick();
    total++; if (mem_write_en !== 1'b0 || owner !== 2'd0) begin bad++; $display("FAIL rst_after got=%b/%0d exp=0/0", mem_write_en, owner); end
    total++; if (env_mem[16] !== ref_mem[16]) begin bad++; $display("FAIL rst_mem got=%h exp=%h", env_mem[16], ref_mem[16]); end
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 600; c++) begin
      if (!m0_req || last_a0) begin
        m0_req = ($urandom_range(0, 9) < 6); m0_we = $urandom_range(0, 1);
        m0_addr = 32'($urandom_range(0, 15)) << 2; m0_wdata = $urandom;
      end
      if (!m1_req || last_a1) begin
        m1_req = ($urandom_range(0, 9) < 6); m1_we = $urandom_range(0, 1);
        m1_addr = 32'($urandom_range(0, 15)) << 2; m1_wdata = $urandom;
      end
      model_edge();
      tick();
      total++; if (owner !== 2'(m_owner)) begin bad++; $display("FAIL rnd_owner c=%0d got=%0d exp=%0d", c, owner, m_owner); end
      total++; if (m0_rvalid !== e_rv0 || m0_rdata !== e_rd0) begin bad++; $display("FAIL rnd_m0 c=%0d got=%b/%h exp=%b/%h", c, m0_rvalid, m0_rdata, e_rv0, e_rd0); end
      total++; if (m1_rvalid !== e_rv1 || m1_rdata !== e_rd1) begin bad++; $display("FAIL rnd_m1 c=%0d got=%b/%h exp=%b/%h", c, m1_rvalid, m1_rdata, e_rv1, e_rd1); end
      total++; if (mem_write_en !== e_we || mem_address !== e_addr) begin bad++; $display("FAIL rnd_issue c=%0d got=%b/%h exp=%b/%h", c, mem_write_en, mem_address, e_we, e_addr); end
      if (e_we) begin
        total++; if (mem_data_in !== e_wdata) begin bad++; $display("FAIL rnd_wdata c=%0d got=%h exp=%h", c, mem_data_in, e_wdata); end
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) begin
      env_mem[i] = 32'hA5A50000 | 32'(i);
      ref_mem[i] = 32'hA5A50000 | 32'(i);
    end
    model_reset();
    test_reset();
    test_write_read();
    test_tie();
    test_back_to_back();
    test_m1_alone();
    test_reset_mid_write();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
